// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Mid-bit sampling UART receiver for the board RX pin. The asynchronous line
// is brought into the i_Clk domain through a two-flop synchroniser. Frames
// (start, DATA_BITS data bits LSB first, optional parity, one stop bit) are
// deserialised and each good byte is presented with a one-cycle valid strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : frame carries a parity bit after the data bits; mismatches
//               pulse o_Parity_Err and suppress o_Valid.
//   undefined : plain DATA_BITS-N-1 framing, o_Parity_Err is tied low.
//
// Parameters:
//   CLKS_PER_BIT : i_Clk cycles per bit period (>= 4)
//   DATA_BITS    : payload bits per frame (5..9)
//   PARITY_ODD   : 0 = even parity, 1 = odd parity (macro builds only)
//
// Ports:
//   i_Clk        : system clock, rising edge
//   i_Rst        : synchronous active-high reset
//   i_Rx         : asynchronous serial line, idles high
//   o_Data       : last good byte, held until the next good frame
//   o_Valid      : one-cycle strobe, o_Data just updated
//   o_Frame_Err  : one-cycle strobe, stop bit sampled low
//   o_Parity_Err : one-cycle strobe, parity mismatch
//   o_Busy       : high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Rx,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] LP_MID      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LP_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LP_IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               r_State;
  state_t               w_Next;
  logic                 r_Rx1;
  logic                 r_RxS;
  logic [CW-1:0]        r_ClkCnt;
  logic [IW-1:0]        r_BitIdx;
  logic [DATA_BITS-1:0] r_Shift;
  logic                 w_SampleBit;
  logic                 w_GoodFrame;
  logic                 w_FrameErr;

`ifdef UART_RX_PARITY_EN
  logic r_ParBit;
  logic w_ParityBad;
  logic w_ParErr;
  logic r_ParityErr;

  assign w_ParityBad  = ((^r_Shift) ^ 1'(PARITY_ODD)) != r_ParBit;
  assign o_Parity_Err = r_ParityErr;
`else
  assign o_Parity_Err = 1'b0;
`endif

  assign o_Busy = (r_State != IDLE);

  // Two-flop synchroniser. Both flops reset high so releasing reset never
  // looks like a falling start edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Rx1 <= 1'b1;
      r_RxS <= 1'b1;
    end else begin
      r_Rx1 <= i_Rx;
      r_RxS <= r_Rx1;
    end
  end

  // State register plus the bit-period timer. The timer restarts on every
  // state change so each state measures from its own entry; within DATA it
  // wraps once per bit so consecutive bits are timed without a state change.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State  <= IDLE;
      r_ClkCnt <= '0;
    end else begin
      r_State <= w_Next;
      if (w_Next != r_State || r_ClkCnt == LP_LAST)
        r_ClkCnt <= '0;
      else
        r_ClkCnt <= r_ClkCnt + CW'(1);
    end
  end

  // Next-state decode and the one-shot decisions made at each sample point.
  // The stop bit is sampled at its middle, so IDLE is re-entered half a bit
  // early and a back-to-back start edge is never missed.
  always_comb begin
    w_Next      = r_State;
    w_SampleBit = 1'b0;
    w_GoodFrame = 1'b0;
    w_FrameErr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_ParErr    = 1'b0;
`endif
    case (r_State)
      IDLE: begin
        if (!r_RxS) w_Next = START;
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (r_ClkCnt == LP_MID) w_Next = r_RxS ? IDLE : DATA;
      end
      DATA: begin
        if (r_ClkCnt == LP_LAST) begin
          w_SampleBit = 1'b1;
          if (r_BitIdx == LP_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_Next = PARITY;
`else
            w_Next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_ClkCnt == LP_LAST) w_Next = STOP;
      end
`endif
      STOP: begin
        if (r_ClkCnt == LP_LAST) begin
          if (!r_RxS) begin
            // Frame error wins over parity; wait for the line to recover so a
            // break is not read as a string of zero frames.
            w_FrameErr = 1'b1;
            w_Next     = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (w_ParityBad) begin
            w_ParErr = 1'b1;
            w_Next   = IDLE;
          end
`endif
          else begin
            w_GoodFrame = 1'b1;
            w_Next      = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_RxS) w_Next = IDLE;
      end
      default: w_Next = IDLE;
    endcase
  end

  // Deserialiser: data bits land LSB first at the running index, which
  // wraps back to zero after the last data bit.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_BitIdx <= '0;
      r_Shift  <= '0;
    end else if (r_State == START) begin
      r_BitIdx <= '0;
    end else if (w_SampleBit) begin
      r_Shift[r_BitIdx] <= r_RxS;
      r_BitIdx          <= (r_BitIdx == LP_IDX_LAST) ? '0 : r_BitIdx + IW'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture at the end of its bit period.
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      r_ParBit <= 1'b0;
    else if (r_State == PARITY && r_ClkCnt == LP_LAST)
      r_ParBit <= r_RxS;
  end

  // Parity error strobe, registered to line up with the other strobes.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_ParityErr <= 1'b0;
    else       r_ParityErr <= w_ParErr;
  end
`endif

  // Output strobes and the held data word. Strobes are registered so they
  // appear in the cycle after the stop-bit sample and last exactly one cycle.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Data      <= '0;
      o_Valid     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      o_Valid     <= w_GoodFrame;
      o_Frame_Err <= w_FrameErr;
      if (w_GoodFrame) o_Data <= r_Shift;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the counterpart of the existing transmit path (tx_timer-based transmitter). It samples an asynchronous serial line at mid-bit using a clock-divided bit timer. It deserialises 8N1 frames, LSB first, and presents each received byte with a one-cycle valid strobe. It sits at the board RX pin, ahead of any command/FIFO logic, and shares the system clock with the TX side.

Parameters:
CLKS_PER_BIT, 868, i_Clk cycles per bit (100 MHz / 115200); legal range ≥ 4.
DATA_BITS, 8, payload bits per frame; legal range 5–9.
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
i_Clk  input  1  system clock; all logic on the rising edge.
i_Rst  input  1  synchronous, active-high reset.
i_Rx  input  1  asynchronous serial line; idles high.
o_Data  output  DATA_BITS  last good byte; held until the next good frame.
o_Valid  output  1  one-cycle strobe: o_Data updated with a good frame.
o_Frame_Err  output  1  one-cycle strobe: stop bit sampled low.
o_Parity_Err  output  1  one-cycle strobe: parity mismatch; tied 0 without the macro.
o_Busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: synchronous, active-high. Takes effect on the clock edge with i_Rst=1 and overrides everything, including a frame in progress. Reset values:
  - state = IDLE; bit counter = 0; clock counter = 0; shift register = 0
  - o_Data = 0; o_Valid = 0; o_Frame_Err = 0; o_Parity_Err = 0; o_Busy = 0
  - synchroniser flops = 1, so no false start on release.
- Synchroniser: i_Rx passes through 2 flops; rx_s is the second flop. All detection uses rx_s, which adds 2 cycles of latency.
- Clock counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. Width = $clog2(CLKS_PER_BIT).
- IDLE:
  - rx_s==0 → START, counter cleared.
  - Otherwise stay in IDLE.
- START:
  - At count == (CLKS_PER_BIT-1)/2 (mid start bit), sample rx_s.
  - rx_s==0 → DATA, bit index 0.
  - rx_s==1 → IDLE. This is glitch rejection: no strobe, no error.
- DATA:
  - At count == CLKS_PER_BIT-1, sample rx_s into bit [index] (LSB first).
  - After index DATA_BITS-1 → PARITY if the macro is defined, else STOP.
  - Index wraps to 0.
- PARITY (macro only):
  - At count == CLKS_PER_BIT-1, sample the parity bit, then → STOP.
- STOP:
  - At count == CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1 and parity OK:
    - o_Data ← shift register; o_Valid=1 for exactly the next cycle → IDLE.
  - rx_s==1 and parity bad:
    - o_Parity_Err=1 for one cycle; o_Data unchanged → IDLE.
  - rx_s==0:
    - o_Frame_Err=1 for one cycle; o_Data unchanged → WAIT_HIGH.
    - Frame error takes precedence over parity error; only one strobe fires.
- WAIT_HIGH:
  - Stay until rx_s==1, then → IDLE. This prevents a break condition from being re-read as back-to-back frames.
- Strobe timing: strobes assert in the cycle after the mid-stop sample and are never asserted together.
- Latency: the first falling edge on i_Rx to o_Valid is 2 + (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles (+ CLKS_PER_BIT with parity).
- Back-to-back frames: IDLE is re-entered mid stop bit, so a start edge arriving at the nominal stop-bit end is detected with no dead time.
- o_Busy is combinational from state.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is start + DATA_BITS + parity + stop.
  - Parity expected = ^data XOR PARITY_ODD.
  - Mismatch pulses o_Parity_Err and suppresses o_Valid.
- Undefined:
  - No PARITY state; frame is 8N1 (DATA_BITS N 1).
  - o_Parity_Err is driven constant 0.

Test Plan:
1. CLKS_PER_BIT=16. Drive frame 0xA5, LSB first, stop=1 → o_Valid single pulse 2+7+144+1=154 cycles after the start edge; o_Data=0xA5; o_Frame_Err=0.
2. Glitch: i_Rx low for 5 cycles, then high → state returns to IDLE; no o_Valid/o_Frame_Err; o_Busy high for ≤ 8 cycles.
3. Frame 0x3C with stop bit held 0, line low for 40 cycles → o_Frame_Err single pulse; o_Data keeps its previous value; o_Busy stays high until 2 cycles after i_Rx returns high; no extra frames.
4. Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three o_Valid pulses exactly 160 cycles apart, data in order.
5. Assert i_Rst during DATA bit 4 of 0x81 → next cycle o_Busy=0, outputs at reset values. A following clean frame 0x81 → o_Valid, o_Data=0x81.
6. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity 1 → o_Valid. Same frame with parity 0 → o_Parity_Err pulse, no o_Valid, o_Data unchanged.
